// File: rtl/seq_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with a valid/ack hold handshake.
// Optional feature: define ROUND_ROBIN_EN for rotating priority; by default the highest set index wins.
module seq_priority_encoder #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         En,
  input  logic [N-1:0] y,
  input  logic         ack,
  output logic [W-1:0] w,
  output logic         valid,
  output logic         multi
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state, stateNext;
  logic [W-1:0] wNext;
  logic         validNext, multiNext;
  logic         cap, load, isMulti;
  logic [W-1:0] winIdx;

  assign cap = En & (|y);

  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  assign isMulti = |(y & (y - N'(1)));

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr, ptrNext;

  function automatic logic [W-1:0] rrWin(input logic [N-1:0] req, input logic [W-1:0] start);
    logic [W-1:0] res;
    logic         found;
    int           idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (!found && req[idx]) begin
        res   = W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    winIdx = rrWin(y, ptr);
  end

  always_comb begin
    ptrNext = ptr;
    if (load) begin
      ptrNext = (winIdx == W'(N - 1)) ? '0 : winIdx + W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ptr <= '0;
    end else begin
      ptr <= ptrNext;
    end
  end
`else
  always_comb begin
    winIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (y[i]) begin
        winIdx = W'(i);
      end
    end
  end
`endif

  // Once a code is presented it stays frozen until ack; ack with a fresh request reloads back-to-back.
  always_comb begin
    stateNext = state;
    wNext     = w;
    multiNext = multi;
    validNext = valid;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          load = 1'b1;
        end
      end
      HOLD: begin
        if (ack) begin
          if (cap) begin
            load = 1'b1;
          end else begin
            validNext = 1'b0;
            stateNext = IDLE;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        validNext = 1'b0;
      end
    endcase
    if (load) begin
      stateNext = HOLD;
      wNext     = winIdx;
      multiNext = isMulti;
      validNext = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      w     <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      state <= stateNext;
      w     <= wNext;
      valid <= validNext;
      multi <= multiNext;
    end
  end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Scoreboard bench for seq_priority_encoder (N=8); expectations follow ROUND_ROBIN_EN when it is defined.
module tb_seq_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         En;
  logic [N-1:0] y;
  logic         ack;
  logic [W-1:0] w;
  logic         valid;
  logic         multi;

  int total = 0;
  int bad   = 0;

  logic [W:0] expQ[$];
  logic       prevValid = 1'b0;
  logic       prevAck   = 1'b0;

  seq_priority_encoder #(.N(N)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .En    (En),
    .y     (y),
    .ack   (ack),
    .w     (w),
    .valid (valid),
    .multi (multi)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input logic [N-1:0] y_v, input logic ack_v);
    En  = en_v;
    y   = y_v;
    ack = ack_v;
  endtask

  task automatic pushExp(input int code, input logic m);
    expQ.push_back({W'(code), m});
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // A new code is presented when valid rises or reloads after an acked edge.
  always @(negedge Clock) begin
    logic [W:0] e;
    if (Resetn && valid && (!prevValid || prevAck)) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: actual w=%0d multi=%0d required=no output", w, multi);
      end else begin
        e = expQ.pop_front();
        checkOutput("scoreboard_w", 32'(w), 32'(e[W:1]));
        checkOutput("scoreboard_multi", 32'(multi), 32'(e[0]));
      end
    end
    prevValid = valid;
    prevAck   = ack;
  end

  initial begin
    Resetn = 1'b0;
    applyStimulus(1'b1, 8'hFF, 1'b0);
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("reset_w", 32'(w), 0);
    checkOutput("reset_valid", 32'(valid), 0);
    checkOutput("reset_multi", 32'(multi), 0);
    pushExp(RR ? 0 : 7, 1'b1);
    Resetn = 1'b1;
    step();
    checkOutput("release_valid", 32'(valid), 1);
    applyStimulus(1'b0, 8'hFF, 1'b1);
    step();
    checkOutput("release_ack_valid", 32'(valid), 0);

    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b1, N'(1) << k, 1'b0);
      pushExp(k, 1'b0);
      step();
      checkOutput("onehot_latency_valid", 32'(valid), 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step();
      checkOutput("onehot_ack_valid", 32'(valid), 0);
    end

    applyStimulus(1'b1, 8'h24, 1'b0);
    pushExp(RR ? 2 : 5, 1'b1);
    step();
    applyStimulus(1'b0, 8'h01, 1'b0);
    repeat (5) begin
      step();
      checkOutput("hold_w", 32'(w), RR ? 2 : 5);
      checkOutput("hold_valid", 32'(valid), 1);
    end

    applyStimulus(1'b1, 8'h08, 1'b1);
    pushExp(3, 1'b0);
    step();
    checkOutput("b2b_valid", 32'(valid), 1);
    applyStimulus(1'b0, 8'h08, 1'b1);
    step();
    checkOutput("ack_drop_valid", 32'(valid), 0);
    checkOutput("ack_keep_w", 32'(w), 3);

    applyStimulus(1'b0, 8'hFF, 1'b1);
    repeat (5) begin
      step();
      checkOutput("gate_en_valid", 32'(valid), 0);
    end
    applyStimulus(1'b1, 8'h00, 1'b1);
    repeat (5) begin
      step();
      checkOutput("gate_zero_valid", 32'(valid), 0);
    end

    applyStimulus(1'b1, 8'h81, 1'b0);
    pushExp(7, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge Clock);
    #1;
    Resetn = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(valid), 0);
    step();
    Resetn = 1'b1;
    step();
    checkOutput("post_reset_valid", 32'(valid), 0);

    applyStimulus(1'b1, 8'hFF, 1'b0);
    pushExp(RR ? 0 : 7, 1'b1);
    step();
    for (int i = 1; i <= N; i++) begin
      applyStimulus(1'b1, 8'hFF, 1'b1);
      pushExp(RR ? (i % N) : 7, 1'b1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h81, 1'b1);
      pushExp(RR ? ((i % 2 == 0) ? 7 : 0) : 7, 1'b1);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    step();
    checkOutput("final_ack_valid", 32'(valid), 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    step();
    checkOutput("queue_empty", 32'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
